fetch_buffer: RTL and testbench

//  Instruction fetch stage feeding the Decoder. Requests 64-byte lines from the Arbiter
//  I-port and keeps them in a circular byte buffer. Presents a 15-byte window plus its RIP
//  to the decoder, which consumes 0..15 bytes per cycle. Redirect restarts fetch at a new RIP.

---
 rtl/fetch_buffer.sv | 182 ++++++++++++++++++
 tb/tb_fetch_buffer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: x86 fetch stage. Pulls 64-byte lines from the Arbiter I-port
// into a circular byte buffer and presents a 15-byte decode window plus RIP.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   entry              start RIP, sampled while reset is high
//   redirect/_rip      flush the buffer and restart fetch at redirect_rip
//   irequest, iaddr    line request to the Arbiter (iaddr line aligned)
//   idata, idone       returned line data and its strobe
//   can_decode         at least WIN_BYTES valid bytes are buffered
//   decode_bytes       window, byte 0 in bits [0:7] is the byte at decode_rip
//   decode_rip         RIP of window byte 0
//   bytes_consumed     bytes the decoder takes this cycle
//   fetch_idle         no request outstanding or pending
module fetch_buffer #(
    parameter int BUF_BYTES  = 128,
    parameter int LINE_BYTES = 64,
    parameter int WIN_BYTES  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect,
    input  logic [63:0]               redirect_rip,
    output logic                      irequest,
    output logic [63:0]               iaddr,
    input  logic [8*LINE_BYTES-1:0]   idata,
    input  logic                      idone,
    output logic                      can_decode,
    output logic [0:8*WIN_BYTES-1]    decode_bytes,
    output logic [63:0]               decode_rip,
    input  logic [3:0]                bytes_consumed,
    output logic                      fetch_idle
);

    localparam int AW = $clog2(BUF_BYTES);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(LINE_BYTES);
    localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   skip_q, skip_d;
    logic [63:0]     fetch_rip_q, fetch_rip_d;
    logic [63:0]     decode_rip_q, decode_rip_d;
    logic [63:0]     iaddr_q, iaddr_d;
    logic            irequest_q, irequest_d;
    logic [7:0]      mem_q [BUF_BYTES];
    logic [7:0]      mem_d [BUF_BYTES];

    logic [PW-1:0]   occ;
    logic            room;
    logic            wr_en;

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_comb begin
        occ        = wr_ptr_q - rd_ptr_q;
        can_decode = (occ >= PW'(WIN_BYTES));
        room       = (occ <= PW'(BUF_BYTES - LINE_BYTES));
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        skip_d       = skip_q;
        fetch_rip_d  = fetch_rip_q;
        decode_rip_d = decode_rip_q;
        iaddr_d      = iaddr_q;
        wr_en        = 1'b0;

        if (redirect) begin
            rd_ptr_d     = wr_ptr_q;
            skip_d       = redirect_rip[LW-1:0];
            fetch_rip_d  = redirect_rip & LINE_MASK;
            decode_rip_d = redirect_rip;
            // An in-flight transfer cannot be cancelled; drain it unless
            // it completes right now, in which case its data is dropped.
            unique case (state_q)
                IDLE:        state_d = IDLE;
                WAIT, DRAIN: state_d = idone ? IDLE : DRAIN;
                default:     state_d = IDLE;
            endcase
        end else begin
            if (can_decode) begin
                rd_ptr_d     = rd_ptr_q + PW'(bytes_consumed);
                decode_rip_d = decode_rip_q + 64'(bytes_consumed);
            end
            unique case (state_q)
                IDLE: begin
                    if (room) begin
                        state_d = WAIT;
                        iaddr_d = fetch_rip_q;
                    end
                end
                WAIT: begin
                    if (idone) begin
                        wr_en       = 1'b1;
                        wr_ptr_d    = wr_ptr_q + PW'(LINE_BYTES);
                        fetch_rip_d = fetch_rip_q + 64'(LINE_BYTES);
                        state_d     = IDLE;
                        // First line after entry/redirect: skip bytes
                        // below the target RIP.
                        if (skip_q != '0) begin
                            rd_ptr_d = wr_ptr_q + PW'(skip_q);
                            skip_d   = '0;
                        end
                    end
                end
                DRAIN: begin
                    if (idone) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        irequest_d = (state_d != IDLE);
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int k = 0; k < LINE_BYTES; k++) begin
                mem_d[wr_ptr_q[AW-1:0] + AW'(k)] = idata[8*k +: 8];
            end
        end
    end

    // Index arithmetic is AW bits wide, so the window wraps naturally.
    always_comb begin
        decode_bytes = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            decode_bytes[8*i +: 8] = mem_q[rd_ptr_q[AW-1:0] + AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            irequest_q   <= 1'b0;
            iaddr_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            skip_q       <= entry[LW-1:0];
            fetch_rip_q  <= entry & LINE_MASK;
            decode_rip_q <= entry;
        end else begin
            state_q      <= state_d;
            irequest_q   <= irequest_d;
            iaddr_q      <= iaddr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            skip_q       <= skip_d;
            fetch_rip_q  <= fetch_rip_d;
            decode_rip_q <= decode_rip_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign irequest   = irequest_q;
    assign iaddr      = iaddr_q;
    assign decode_rip = decode_rip_q;
    assign fetch_idle = (state_q == IDLE) && !irequest_q;

    consume_needs_window: assert property (
        @(posedge clk) disable iff (reset)
        !((bytes_consumed != 4'd0) && !can_decode)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: randomized bench for fetch_buffer with an address-level
// model (decoder sees memory bytes from its RIP up to the last fetched line).
module tb_fetch_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  entry;
    logic         redirect;
    logic [63:0]  redirect_rip;
    logic         irequest;
    logic [63:0]  iaddr;
    logic [511:0] idata;
    logic         idone;
    logic         can_decode;
    logic [0:119] decode_bytes;
    logic [63:0]  decode_rip;
    logic [3:0]   bytes_consumed;
    logic         fetch_idle;

    int total = 0;
    int bad   = 0;

    // Model: buffered bytes are addresses [m_rip, m_end).
    logic [63:0] m_rip, m_end, m_next, m_addr, last_iaddr;
    bit          m_open, m_stale;
    int          lat_cnt, lat_cfg, n_done;

    fetch_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect       (redirect),
        .redirect_rip   (redirect_rip),
        .irequest       (irequest),
        .iaddr          (iaddr),
        .idata          (idata),
        .idone          (idone),
        .can_decode     (can_decode),
        .decode_bytes   (decode_bytes),
        .decode_rip     (decode_rip),
        .bytes_consumed (bytes_consumed),
        .fetch_idle     (fetch_idle)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    function automatic logic [63:0] m_occ();
        return (m_end > m_rip) ? m_end - m_rip : 64'd0;
    endfunction

    // One cycle: compare outputs with the model, act as Arbiter and
    // decoder, advance the model, move to the next falling edge.
    task automatic step(input int cons, input bit redir,
                        input logic [63:0] rrip);
        logic [63:0]  occ_m;
        logic [0:119] win;
        logic [3:0]   c;
        bit           idn;
        occ_m = m_occ();
        total++;
        if (decode_rip !== m_rip) begin
            bad++;
            $display("FAIL decode_rip got=%h exp=%h", decode_rip, m_rip);
        end
        total++;
        if (can_decode !== (occ_m >= 64'd15)) begin
            bad++;
            $display("FAIL can_decode got=%b exp=%b occ=%0d",
                     can_decode, occ_m >= 64'd15, occ_m);
        end
        if (occ_m >= 64'd15) begin
            for (int i = 0; i < 15; i++)
                win[8*i +: 8] = memf(m_rip + 64'(i));
            total++;
            if (decode_bytes !== win) begin
                bad++;
                $display("FAIL window got=%h exp=%h", decode_bytes, win);
            end
        end
        if (m_open) begin
            total++;
            if (irequest !== 1'b1) begin
                bad++;
                $display("FAIL irequest_hold got=%b exp=1", irequest);
                m_open  = 1'b0;
                m_stale = 1'b0;
            end
        end
        idn = 1'b0;
        if (irequest === 1'b1) begin
            if (!m_open) begin
                total++;
                if (iaddr !== m_next) begin
                    bad++;
                    $display("FAIL iaddr got=%h exp=%h", iaddr, m_next);
                end
                total++;
                if (occ_m > 64'd64) begin
                    bad++;
                    $display("FAIL room occ=%0d exp<=64", occ_m);
                end
                m_open     = 1'b1;
                m_addr     = iaddr;
                last_iaddr = iaddr;
                lat_cnt    = (lat_cfg < 0) ? int'($urandom_range(0, 5))
                                           : lat_cfg;
            end else begin
                total++;
                if (iaddr !== m_addr) begin
                    bad++;
                    $display("FAIL iaddr_stable got=%h exp=%h", iaddr, m_addr);
                end
            end
            if (lat_cnt == 0) idn = 1'b1;
            else lat_cnt--;
        end
        for (int k = 0; k < 64; k++)
            idata[8*k +: 8] = memf(m_addr + 64'(k));
        c = 4'd0;
        if (can_decode === 1'b1)
            c = (cons < 0) ? 4'($urandom_range(0, 15)) : 4'(cons);
        bytes_consumed = c;
        redirect       = redir;
        redirect_rip   = rrip;
        idone          = idn;
        if (idn) n_done++;
        if (redir) begin
            m_rip  = rrip;
            m_end  = rrip;
            m_next = rrip & ~64'h3F;
            if (idn) begin
                m_open  = 1'b0;
                m_stale = 1'b0;
            end else if (m_open) begin
                m_stale = 1'b1;
            end
        end else begin
            if (idn) begin
                if (!m_stale) begin
                    m_end  = m_addr + 64'd64;
                    m_next = m_addr + 64'd64;
                end
                m_open  = 1'b0;
                m_stale = 1'b0;
            end
            m_rip = m_rip + 64'(c);
        end
        @(negedge clk);
        redirect       = 1'b0;
        idone          = 1'b0;
        bytes_consumed = 4'd0;
    endtask

    task automatic test_reset(input logic [63:0] e);
        reset          = 1'b1;
        entry          = e;
        redirect       = 1'b0;
        redirect_rip   = '0;
        idone          = 1'b0;
        bytes_consumed = 4'd0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (irequest !== 1'b0) begin
            bad++; $display("FAIL rst_irequest got=%b exp=0", irequest);
        end
        total++;
        if (iaddr !== 64'd0) begin
            bad++; $display("FAIL rst_iaddr got=%h exp=0", iaddr);
        end
        total++;
        if (can_decode !== 1'b0) begin
            bad++; $display("FAIL rst_can_decode got=%b exp=0", can_decode);
        end
        total++;
        if (fetch_idle !== 1'b1) begin
            bad++; $display("FAIL rst_fetch_idle got=%b exp=1", fetch_idle);
        end
        total++;
        if (decode_rip !== e) begin
            bad++; $display("FAIL rst_decode_rip got=%h exp=%h", decode_rip, e);
        end
        reset   = 1'b0;
        m_rip   = e;
        m_end   = e;
        m_next  = e & ~64'h3F;
        m_addr  = '0;
        m_open  = 1'b0;
        m_stale = 1'b0;
        lat_cnt = 0;
    endtask

    task automatic test_first_line();
        int g;
        int base;
        lat_cfg = 3;
        test_reset(64'h1000_0008);
        base = n_done;
        g = 0;
        while (n_done == base && g < 40) begin step(0, 0, '0); g++; end
        total++;
        if (can_decode !== 1'b1) begin
            bad++; $display("FAIL first_can_decode got=%b exp=1", can_decode);
        end
        total++;
        if (last_iaddr !== 64'h1000_0000) begin
            bad++; $display("FAIL first_iaddr got=%h exp=10000000", last_iaddr);
        end
        total++;
        if (decode_bytes[0:7] !== 8'h08 || decode_bytes[112:119] !== 8'h16) begin
            bad++;
            $display("FAIL first_window got=%h exp=08..16", decode_bytes);
        end
        for (int i = 0; i < 30; i++) step(0, 0, '0);
        total++;
        if (fetch_idle !== 1'b1 || irequest !== 1'b0) begin
            bad++;
            $display("FAIL full_idle got=%b/%b exp=1/0", fetch_idle, irequest);
        end
    endtask

    task automatic test_stream();
        int base;
        lat_cfg = 5;
        test_reset(64'h1000_0000);
        base = n_done;
        for (int i = 0; i < 300; i++) step(15, 0, '0);
        total++;
        if (n_done - base < 20) begin
            bad++; $display("FAIL stream_lines got=%0d exp>=20", n_done - base);
        end
    endtask

    task automatic test_wrap();
        int g;
        lat_cfg = 20;
        test_reset(64'h3000_0000);
        g = 0;
        while (m_occ() != 64'd128 && g < 200) begin step(0, 0, '0); g++; end
        for (int i = 0; i < 8; i++) step(15, 0, '0);
        g = 0;
        while (can_decode !== 1'b1 && g < 60) begin step(0, 0, '0); g++; end
        total++;
        if (decode_rip !== 64'h3000_0078 || can_decode !== 1'b1) begin
            bad++;
            $display("FAIL wrap_rip got=%h/%b exp=30000078/1",
                     decode_rip, can_decode);
        end
        total++;
        if (decode_bytes[0:7] !== 8'h78 || decode_bytes[64:71] !== 8'h80) begin
            bad++; $display("FAIL wrap_window got=%h", decode_bytes);
        end
        for (int i = 0; i < 40; i++) step(-1, 0, '0);
    endtask

    task automatic test_redirect_wait();
        int g;
        lat_cfg = 6;
        test_reset(64'h1000_0000);
        g = 0;
        while (!m_open && g < 20) begin step(0, 0, '0); g++; end
        step(0, 1, 64'h2000_0030);
        g = 0;
        while (can_decode !== 1'b1 && g < 60) begin step(0, 0, '0); g++; end
        total++;
        if (last_iaddr !== 64'h2000_0000) begin
            bad++; $display("FAIL redir_iaddr got=%h exp=20000000", last_iaddr);
        end
        total++;
        if (decode_rip !== 64'h2000_0030 || decode_bytes[0:7] !== 8'h30) begin
            bad++;
            $display("FAIL redir_window got=%h/%h exp=20000030/30",
                     decode_rip, decode_bytes[0:7]);
        end
    endtask

    task automatic test_redirect_idone();
        int g;
        int base;
        lat_cfg = 3;
        test_reset(64'h1000_0000);
        g = 0;
        while (!(m_open && lat_cnt == 0) && g < 20) begin
            step(0, 0, '0); g++;
        end
        step(0, 1, 64'h4000_0010);
        total++;
        if (can_decode !== 1'b0 || irequest !== 1'b0) begin
            bad++;
            $display("FAIL redir_done got=%b/%b exp=0/0", can_decode, irequest);
        end
        base = n_done;
        g = 0;
        while (irequest !== 1'b1 && g < 20) begin step(0, 0, '0); g++; end
        total++;
        if (iaddr !== 64'h4000_0000) begin
            bad++; $display("FAIL redir_done_iaddr got=%h exp=40000000", iaddr);
        end
        g = 0;
        while (n_done == base && g < 40) begin step(0, 0, '0); g++; end
        total++;
        if (decode_rip !== 64'h4000_0010 || can_decode !== 1'b1) begin
            bad++;
            $display("FAIL redir_done_rip got=%h/%b", decode_rip, can_decode);
        end
    endtask

    task automatic test_skip_large();
        int g;
        int base;
        lat_cfg = 2;
        test_reset(64'h5000_003C);
        base = n_done;
        g = 0;
        while (n_done == base && g < 40) begin step(0, 0, '0); g++; end
        total++;
        if (can_decode !== 1'b0) begin
            bad++; $display("FAIL skip_occ4 got=%b exp=0", can_decode);
        end
        g = 0;
        while (n_done == base + 1 && g < 40) begin step(0, 0, '0); g++; end
        total++;
        if (can_decode !== 1'b1 || decode_bytes[0:7] !== 8'h3C) begin
            bad++;
            $display("FAIL skip_occ68 got=%b/%h exp=1/3c",
                     can_decode, decode_bytes[0:7]);
        end
        for (int i = 0; i < 10; i++) step(0, 0, '0);
        total++;
        if (irequest !== 1'b0 || fetch_idle !== 1'b1) begin
            bad++;
            $display("FAIL skip_norequest got=%b/%b exp=0/1",
                     irequest, fetch_idle);
        end
    endtask

    task automatic test_reset_mid_wait();
        int g;
        int base;
        lat_cfg = 10;
        test_reset(64'h6000_0000);
        g = 0;
        while (!m_open && g < 20) begin step(0, 0, '0); g++; end
        step(0, 0, '0);
        step(0, 0, '0);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (irequest !== 1'b0 || fetch_idle !== 1'b1 || can_decode !== 1'b0) begin
            bad++;
            $display("FAIL midwait_reset got=%b/%b/%b exp=0/1/0",
                     irequest, fetch_idle, can_decode);
        end
        lat_cfg = 1;
        test_reset(64'h6000_0000);
        base = n_done;
        g = 0;
        while (n_done == base && g < 40) begin step(0, 0, '0); g++; end
        total++;
        if (can_decode !== 1'b1) begin
            bad++; $display("FAIL midwait_restart got=%b exp=1", can_decode);
        end
    endtask

    task automatic test_random();
        int base;
        bit r;
        lat_cfg = -1;
        test_reset({32'h0, $urandom});
        base = n_done;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 99) < 3);
            step(-1, r, {1'b0, 31'($urandom), $urandom});
        end
        total++;
        if (n_done == base) begin
            bad++; $display("FAIL random_no_lines got=0 exp>0");
        end
    endtask

    initial begin
        n_done     = 0;
        lat_cfg    = 3;
        idata      = '0;
        last_iaddr = '0;
        test_reset(64'h1000_0008);
        test_first_line();
        test_stream();
        test_wrap();
        test_redirect_wait();
        test_redirect_idone();
        test_skip_large();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
